// File: rtl/isr_sequencer.sv
// isr_sequencer
//   Interrupt entry/exit sequencer. On a jump-to-ISR request it saves the
//   status context into exception SPRs, drops to system mode and redirects
//   the PC to SISR. On a return-from-exception instruction it restores the
//   context and redirects the PC to the saved epc.
// Ports:
//   clk, rst (async, active-low)
//   jisr, mca[22:0], rpt   : interrupt request, masked cause, repeat select
//   pc, next_pc, ea        : current PC, successor PC, effective address
//   instruction, instr_valid : instruction in execute (rfe detection)
//   sprw, reg_sel, data_in : software SPR write port
//   spr_out                : combinational SPR read (selected by reg_sel)
//   sr, mode               : status register, 1 = user / 0 = system
//   pc_load, pc_target     : one-cycle PC redirect
//   stall                  : pipeline hold while the sequence is running
module isr_sequencer #(
  parameter logic [31:0] SISR   = 32'h0000_0000,
  parameter logic [5:0]  RFE_OP = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jisr,
  input  logic [22:0] mca,
  input  logic        rpt,
  input  logic [31:0] pc,
  input  logic [31:0] next_pc,
  input  logic [31:0] ea,
  input  logic [31:0] instruction,
  input  logic        instr_valid,
  input  logic        sprw,
  input  logic [2:0]  reg_sel,
  input  logic [31:0] data_in,
  output logic [31:0] spr_out,
  output logic [31:0] sr,
  output logic [31:0] mode,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        stall
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE,
    ST_VECTOR,
    ST_RESTORE,
    ST_RETURN
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] esr, eca, epc, edata, emode;
  logic [2:0]  depth;
  logic        pending;
  logic        take_isr;
  logic        is_rfe;

  // A request latched while busy is serviced exactly like a live jisr.
  assign take_isr = jisr || pending;
  assign is_rfe   = instr_valid && (instruction[31:26] == RFE_OP) && (mode == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (take_isr)    state_nxt = ST_SAVE;
        else if (is_rfe) state_nxt = ST_RESTORE;
      end
      ST_SAVE:    state_nxt = ST_VECTOR;
      ST_VECTOR:  state_nxt = ST_IDLE;
      ST_RESTORE: state_nxt = ST_RETURN;
      ST_RETURN:  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_load   = 1'b0;
    pc_target = '0;
    stall     = (state != ST_IDLE);
    case (state)
      ST_VECTOR: begin
        pc_load   = 1'b1;
        pc_target = SISR;
      end
      ST_RETURN: begin
        pc_load   = 1'b1;
        pc_target = epc;
      end
      default: ;
    endcase
  end

  // Software write is applied first; hardware updates below override it
  // for any register both touch in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      esr     <= '0;
      eca     <= '0;
      epc     <= '0;
      edata   <= '0;
      mode    <= '0;
      emode   <= '0;
      depth   <= '0;
      pending <= 1'b0;
    end else begin
      if (state == ST_IDLE && mode == '0 && sprw) begin
        case (reg_sel)
          3'd0: sr    <= data_in;
          3'd1: esr   <= data_in;
          3'd2: eca   <= data_in;
          3'd3: epc   <= data_in;
          3'd4: edata <= data_in;
          3'd5: mode  <= data_in;
          3'd6: emode <= data_in;
          default: ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (take_isr) begin
            esr   <= sr;
            eca   <= {9'b0, mca};
            epc   <= rpt ? pc : next_pc;
            edata <= ea;
            emode <= mode;
          end
        end
        ST_SAVE: begin
          sr   <= '0;
          mode <= '0;
          if (depth != 3'd7) depth <= depth + 3'd1;
        end
        ST_RESTORE: begin
          sr   <= esr;
          mode <= emode;
          if (depth != 3'd0) depth <= depth - 3'd1;
        end
        default: ;
      endcase

      // Any pending request is consumed by the IDLE cycle that enters SAVE.
      if (state == ST_IDLE) pending <= 1'b0;
      else if (jisr)        pending <= 1'b1;
    end
  end

  always_comb begin
    spr_out = '0;
    case (reg_sel)
      3'd0: spr_out = sr;
      3'd1: spr_out = esr;
      3'd2: spr_out = eca;
      3'd3: spr_out = epc;
      3'd4: spr_out = edata;
      3'd5: spr_out = mode;
      3'd6: spr_out = emode;
      3'd7: spr_out = {29'b0, depth};
      default: spr_out = '0;
    endcase
  end

endmodule

// File: tb/tb_isr_sequencer.sv
// tb_isr_sequencer
//   Directed bench for isr_sequencer. Every expected PC redirect target is
//   queued when the request is issued and popped when pc_load is seen.
module tb_isr_sequencer;

  localparam logic [31:0] SISR_V = 32'h0000_0800;
  localparam logic [31:0] RFE_I  = 32'hFC00_0000;

  logic        clk, rst, jisr, rpt, instr_valid, sprw;
  logic [22:0] mca;
  logic [31:0] pc, next_pc, ea, instruction, data_in;
  logic [2:0]  reg_sel;
  logic [31:0] spr_out, sr, mode, pc_target;
  logic        pc_load, stall;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_q[$];

  isr_sequencer #(.SISR(SISR_V), .RFE_OP(6'b111111)) dut (
    .clk(clk), .rst(rst), .jisr(jisr), .mca(mca), .rpt(rpt),
    .pc(pc), .next_pc(next_pc), .ea(ea),
    .instruction(instruction), .instr_valid(instr_valid),
    .sprw(sprw), .reg_sel(reg_sel), .data_in(data_in),
    .spr_out(spr_out), .sr(sr), .mode(mode),
    .pc_load(pc_load), .pc_target(pc_target), .stall(stall)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] sel, input string tag, input logic [31:0] exp);
    reg_sel = sel;
    #1;
    chk(tag, spr_out, exp);
  endtask

  // Compare the current redirect against the oldest queued target.
  task automatic pop_redirect(input string tag);
    logic [31:0] e;
    chk({tag, "_load"}, {31'b0, pc_load}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_target"}, pc_target, e);
    end
  endtask

  task automatic swr(input logic [2:0] sel, input logic [31:0] d);
    sprw = 1'b1; reg_sel = sel; data_in = d;
    tick();
    sprw = 1'b0;
  endtask

  initial begin
    rst = 1'b0; jisr = 1'b0; rpt = 1'b0; instr_valid = 1'b0; sprw = 1'b0;
    mca = '0; pc = '0; next_pc = '0; ea = '0; instruction = '0;
    data_in = '0; reg_sel = '0;
    #3;
    chk("rst_sr", sr, 32'd0);
    chk("rst_mode", mode, 32'd0);
    chk("rst_pc_load", {31'b0, pc_load}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    rd(3'd7, "rst_depth", 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // rfe at depth 0: depth stays at 0, returns to epc (0 after reset)
    instruction = RFE_I; instr_valid = 1'b1; exp_q.push_back(32'h0);
    tick();
    instr_valid = 1'b0;
    chk("rfe0_stall", {31'b0, stall}, 32'd1);
    tick();
    pop_redirect("rfe0");
    rd(3'd7, "rfe0_depth", 32'd0);
    tick();

    // set up sr=3, mode=1 via software writes, then a user-mode write is dropped
    swr(3'd0, 32'h3);
    swr(3'd5, 32'h1);
    chk("setup_sr", sr, 32'h3);
    chk("setup_mode", mode, 32'h1);
    swr(3'd0, 32'hFF);
    chk("user_wr_sr", sr, 32'h3);

    // ISR entry from user mode
    jisr = 1'b1; mca = 23'h000004; rpt = 1'b0; pc = 32'h100; next_pc = 32'h104; ea = 32'hABCD;
    exp_q.push_back(SISR_V);
    tick();
    jisr = 1'b0;
    rd(3'd1, "entry_esr", 32'h3);
    rd(3'd2, "entry_eca", 32'h4);
    rd(3'd3, "entry_epc", 32'h104);
    rd(3'd6, "entry_emode", 32'h1);
    chk("entry_no_load_save", {31'b0, pc_load}, 32'd0);
    tick();
    chk("entry_sr", sr, 32'h0);
    chk("entry_mode", mode, 32'h0);
    pop_redirect("entry");
    rd(3'd7, "entry_depth", 32'd1);
    tick();
    chk("entry_idle_stall", {31'b0, stall}, 32'd0);

    // return from exception
    instruction = RFE_I; instr_valid = 1'b1; exp_q.push_back(32'h104);
    tick();
    instr_valid = 1'b0;
    chk("rfe_stall1", {31'b0, stall}, 32'd1);
    tick();
    chk("rfe_stall2", {31'b0, stall}, 32'd1);
    pop_redirect("rfe");
    chk("rfe_sr", sr, 32'h3);
    chk("rfe_mode", mode, 32'h1);
    rd(3'd7, "rfe_depth", 32'd0);
    tick();
    chk("rfe_stall_end", {31'b0, stall}, 32'd0);

    // rfe in user mode is ignored
    instruction = RFE_I; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("user_rfe_stall", {31'b0, stall}, 32'd0);
    chk("user_rfe_load", {31'b0, pc_load}, 32'd0);

    // rpt=1 saves pc
    jisr = 1'b1; rpt = 1'b1; pc = 32'h200; exp_q.push_back(SISR_V);
    tick();
    jisr = 1'b0; rpt = 1'b0;
    rd(3'd3, "rpt_epc", 32'h200);
    tick();
    pop_redirect("rpt");
    tick();

    // jisr and rfe together in system mode: ISR entry wins
    jisr = 1'b1; next_pc = 32'h300; instruction = RFE_I; instr_valid = 1'b1;
    exp_q.push_back(SISR_V);
    tick();
    jisr = 1'b0; instr_valid = 1'b0;
    rd(3'd3, "both_epc", 32'h300);
    tick();
    pop_redirect("both");
    rd(3'd7, "both_depth", 32'd2);
    tick();

    // system-mode writes: sr writable, depth read-only
    swr(3'd0, 32'hFF);
    chk("sys_wr_sr", sr, 32'hFF);
    swr(3'd7, 32'h5);
    rd(3'd7, "ro_depth", 32'd2);

    // hardware save beats a software write to epc in the same cycle
    jisr = 1'b1; rpt = 1'b1; pc = 32'h400;
    sprw = 1'b1; reg_sel = 3'd3; data_in = 32'hDEAD;
    exp_q.push_back(SISR_V);
    tick();
    jisr = 1'b0; rpt = 1'b0; sprw = 1'b0;
    rd(3'd3, "hw_wins_epc", 32'h400);
    tick();
    pop_redirect("hw_wins");
    tick();

    // jisr during RESTORE: return completes, then pending is serviced
    instruction = RFE_I; instr_valid = 1'b1; exp_q.push_back(32'h400);
    tick();
    instr_valid = 1'b0;
    jisr = 1'b1; mca = 23'h7; next_pc = 32'h500;
    tick();
    jisr = 1'b0;
    pop_redirect("pend_ret");
    exp_q.push_back(SISR_V);
    tick();
    chk("pend_idle_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("pend_save_stall", {31'b0, stall}, 32'd1);
    rd(3'd3, "pend_epc", 32'h500);
    rd(3'd2, "pend_eca", 32'h7);
    tick();
    pop_redirect("pend_vec");
    tick(); tick();
    chk("pend_cleared", {31'b0, stall}, 32'd0);

    // reset asserted while in VECTOR
    jisr = 1'b1;
    tick();
    jisr = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("rstv_pc_load", {31'b0, pc_load}, 32'd0);
    chk("rstv_target", pc_target, 32'd0);
    chk("rstv_stall", {31'b0, stall}, 32'd0);
    chk("rstv_sr", sr, 32'd0);
    rd(3'd7, "rstv_depth", 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstv_hold_load", {31'b0, pc_load}, 32'd0);
    end
    rst = 1'b1;
    tick();
    chk("rstv_after_stall", {31'b0, stall}, 32'd0);
    chk("rstv_after_load", {31'b0, pc_load}, 32'd0);

    // nine nested entries: depth saturates at 7
    for (int i = 0; i < 9; i++) begin
      jisr = 1'b1; exp_q.push_back(SISR_V);
      tick();
      jisr = 1'b0;
      tick();
      pop_redirect("nest");
      tick();
    end
    rd(3'd7, "nest_depth", 32'd7);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/isr_sequencer.md
ISR_SEQUENCER -- requirements
Module: isr_sequencer

Interface
REQ-001 Parameter SISR, default 32'h0000_0000, interrupt service routine start address.
REQ-002 Parameter RFE_OP, default 6'b111111, opcode of the return-from-exception instruction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 jisr  input  1  jump-to-ISR request from the interrupt controller.
REQ-006 mca  input  23  masked cause vector accompanying jisr.
REQ-007 rpt  input  1  repeat: 1 = save pc, 0 = save next_pc.
REQ-008 pc, next_pc, ea  input  32 each  current PC, successor PC, effective address.
REQ-009 instruction  input  32  instruction in execute; instr_valid  input  1  qualifies it.
REQ-010 sprw  input  1  SPR write enable; reg_sel  input  3  SPR select; data_in  input  32  write data.
REQ-011 spr_out  output  32  combinational read of the SPR selected by reg_sel.
REQ-012 sr  output  32  status register; mode  output  32  1 = user, 0 = system.
REQ-013 pc_load  output  1  one-cycle PC redirect strobe; pc_target  output  32  redirect address.
REQ-014 stall  output  1  pipeline hold, high in every state other than IDLE.

Function
REQ-015 SPR map by reg_sel: 0 sr, 1 esr, 2 eca, 3 epc, 4 edata, 5 mode, 6 emode, 7 depth; depth is read-only, and writes to it are dropped.
REQ-016 The FSM shall have states IDLE, SAVE, VECTOR, RESTORE and RETURN.
REQ-017 IDLE with jisr=1: on the edge, esr<=sr, eca<={9'b0,mca}, epc<=(rpt ? pc : next_pc), edata<=ea, emode<=mode, and the FSM goes to SAVE.
REQ-018 SAVE: sr<=0, mode<=0, depth<=depth+1 saturating at 7, then go to VECTOR.
REQ-019 VECTOR: pc_load=1 and pc_target=SISR for exactly one cycle, then go to IDLE.
REQ-020 IDLE with instr_valid=1, instruction[31:26]=RFE_OP, mode=0 and jisr=0: go to RESTORE.
REQ-021 RESTORE: sr<=esr, mode<=emode, depth<=depth-1 saturating at 0, then go to RETURN.
REQ-022 RETURN: pc_load=1 and pc_target=epc for one cycle, then go to IDLE.
REQ-023 rfe with mode=1 shall be ignored, with no state change; illegal-instruction cause is signalled elsewhere.
REQ-024 jisr and rfe together in IDLE: jisr wins and rfe is discarded.
REQ-025 jisr asserted outside IDLE shall set a pending flag; pending is serviced as jisr in the first IDLE cycle, using mca/pc/next_pc/ea sampled in that cycle, and is cleared on entry to SAVE.
REQ-026 When a hardware update and an sprw write hit the same register in the same cycle, the hardware update wins.
REQ-027 sprw is honoured only in IDLE with mode=0; it is otherwise dropped.
REQ-028 Outside VECTOR and RETURN, pc_load=0 and pc_target=0.
REQ-029 Latency: jisr sampled at edge N gives pc_load high during cycle N+2; rfe behaves the same way.

Reset
REQ-030 While rst=0, the FSM is forced to IDLE immediately, independent of clk.
REQ-031 While rst=0, all SPRs, depth and the pending flag are forced to 0, and pc_load=0, stall=0.
REQ-032 Reset mid-sequence (SAVE, VECTOR, RESTORE or RETURN) shall abort it with no pc_load emitted.
REQ-033 The first active edge after rst rises shall be treated as IDLE.

Verification
REQ-034 sr=32'h3, mode=1, jisr=1, mca=23'h000004, rpt=0, next_pc=32'h104 -> esr=3, eca=4, epc=32'h104, emode=1; two cycles later sr=0, mode=0, pc_load=1 with pc_target=SISR; depth=1.
REQ-035 Follow with rfe (instruction[31:26]=6'b111111, instr_valid=1) -> sr=3, mode=1, pc_load=1 with pc_target=32'h104; depth=0; stall high for exactly 2 cycles.
REQ-036 jisr=1 with rpt=1, pc=32'h200 -> epc=32'h200; jisr and rfe in the same IDLE cycle -> ISR entry only, and epc is not loaded as target.
REQ-037 jisr pulsed during RESTORE -> RETURN completes to epc, then SAVE starts on the next cycle, and pending clears.
REQ-038 mode=1 with sprw=1, reg_sel=0, data_in=32'hFF -> sr unchanged; mode=0 with the same write -> sr=32'hFF; a write with reg_sel=7 -> depth unchanged.
REQ-039 rst driven low in VECTOR -> all outputs 0 immediately, no pc_load pulse; nine nested jisr without rfe -> depth saturates at 7.
